pipelined_cla_adder: RTL
========================

// Module: pipelined_cla_adder
// PURPOSE
//  Parametrised, pipelined add/subtract unit. Operands are split into CHUNK-bit slices; each
//  slice is added in its own pipeline stage, with the carry registered between stages.
//  Carry-lookahead is used inside each slice. The block replaces the flat 32-bit ripple-of-CLA
//  adder in ALU/MAC datapaths that need a higher clock rate, subtract-with-borrow and flags.
//  A valid/ready handshake sits on both sides.
// PARAMETERS
//  WIDTH  32  operand/result width; must be a multiple of CHUNK
//  CHUNK   8  slice width per stage, 1..WIDTH; NCH = WIDTH/CHUNK (localparam) = pipeline depth
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand set present on a/b/cin/sub
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: a+b+cin; 1: a-b-cin
//  out_valid  out  1      result present
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      raw carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      signed two's-complement overflow
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): every stage valid bit=0, all data/carry regs=0; so out_valid=0,
//    sum=0, cout=0, ovf=0, zero=0. in_ready=1 once reset is released.
//  - Global advance enable: en = !out_valid | out_ready; in_ready = en (combinational).
//    Transfers: in_valid&in_ready (input), out_valid&out_ready (output).
//  - Stage 0 captures on en: beff = sub ? ~b : b; c0 = sub ? ~cin : cin.
//    Stage 0 adds slice 0 as a[CHUNK-1:0] + beff[CHUNK-1:0] + c0.
//    Stage 0 registers: slice-0 sum, carry, the untouched upper a/beff slices (skew),
//    a[MSB], beff[MSB] and valid=in_valid.
//  - Stage k (1..NCH-1) on en: adds slice k of its skewed operands plus the registered carry.
//    It forwards the lower sums, remaining upper slices and the valid bit.
//  - Last stage regs drive the outputs. cout = carry out of slice NCH-1.
//    ovf = (aMSB == beffMSB) & (sum[WIDTH-1] != aMSB). zero = ~|sum.
//    All four are registered with the data.
//  - Latency: exactly NCH cycles from input transfer to out_valid, with no stalls.
//    Throughput is 1 result/cycle.
//  - Stall (out_valid & !out_ready): the whole pipe freezes, in_ready=0, and every output is
//    held stable. Bubbles are NOT collapsed; invalid stages advance only with en.
//  - A cycle with en=1 and in_valid=0 inserts a bubble (stage-0 valid=0). Bubble data is
//    don't-care, but outputs hold their last values while out_valid=0.
//  - Simultaneous output transfer and input transfer in one cycle is legal and loses nothing.
//  - CHUNK == WIDTH degenerates to a single-stage registered adder (NCH=1).
//  - rst_n asserted mid-operation: all in-flight results are discarded immediately and
//    nothing is emitted afterwards.
//  - in_valid must be held, with stable operands, until accepted.
//    out_valid stays high until out_ready.
// TESTING
//  1. Reset, default params: a=FFFFFFFF b=00000000 cin=1 sub=0, out_ready=1
//     -> 4 cycles later out_valid=1, sum=0, cout=1, zero=1, ovf=0.
//  2. sub=1 a=5 b=7 cin=0 -> sum=FFFFFFFE, cout=0, ovf=0, zero=0;
//     a=80000000 b=1 sub=1 -> sum=7FFFFFFF, ovf=1, cout=1.
//  3. Add a=7FFFFFFF b=1 -> sum=80000000, ovf=1, cout=0.
//     Chain 64-bit add FFFFFFFF_FFFFFFFF+1 via cout->cin -> 0_00000000, final cout=1.
//  4. Stream 20 back-to-back ops; drop out_ready for 3 cycles mid-stream.
//     -> in_ready=0 during the stall, outputs held, all 20 results correct and in order.
//  5. Assert rst_n while 3 ops are in flight -> outputs immediately 0, out_valid=0,
//     and no stale result appears after release.
//  6. WIDTH=16 CHUNK=4 and WIDTH=32 CHUNK=32: 10k random ops with random handshakes
//     vs a behavioural model -> zero mismatches, and latency equals NCH (4 and 1).

Source files
------------

// File: rtl/pipelined_cla_adder_if.sv
// rtl/pipelined_cla_adder_if.sv - operand/result handshake bundle for the pipelined add/subtract unit
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined add/subtract, one CHUNK-bit lookahead slice per stage
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;

    logic [WIDTH-1:0] a_q [NCH];
    logic [WIDTH-1:0] b_q [NCH];
    logic [WIDTH-1:0] s_q [NCH];
    logic [NCH-1:0]   c_q;
    logic [NCH-1:0]   v_q;
    logic             ovf_q;
    logic             zero_q;

    logic [WIDTH-1:0] a_d [NCH];
    logic [WIDTH-1:0] b_d [NCH];
    logic [WIDTH-1:0] s_d [NCH];
    logic [NCH-1:0]   c_d;
    logic [NCH-1:0]   v_d;
    logic             ovf_d;
    logic             zero_d;

    logic [CHUNK:0]   slice_r [NCH];
    logic [WIDTH-1:0] beff;
    logic             c0;
    logic             en;

    // Flat sum-of-products carries: every carry is generated directly from g/p and ci.
    function automatic logic [CHUNK:0] cla_slice(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK:0]   c;
        logic             term;
        logic             prop;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            term = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = term | (prop & ci);
        end
        return {c[CHUNK], p ^ c[CHUNK-1:0]};
    endfunction

    assign en = !v_q[NCH-1] | bus.out_ready;

    always_comb begin
        beff = bus.sub ? ~bus.b : bus.b;
        c0   = bus.sub ? ~bus.cin : bus.cin;

        slice_r[0]           = cla_slice(bus.a[CHUNK-1:0], beff[CHUNK-1:0], c0);
        a_d[0]               = bus.a;
        b_d[0]               = beff;
        s_d[0]               = '0;
        s_d[0][CHUNK-1:0]    = slice_r[0][CHUNK-1:0];
        c_d[0]               = slice_r[0][CHUNK];
        v_d[0]               = bus.in_valid;

        // Later stages consume the slice of the skewed operands that matches their index.
        for (int k = 1; k < NCH; k++) begin
            slice_r[k]                = cla_slice(a_q[k-1][k*CHUNK +: CHUNK],
                                                  b_q[k-1][k*CHUNK +: CHUNK], c_q[k-1]);
            a_d[k]                    = a_q[k-1];
            b_d[k]                    = b_q[k-1];
            s_d[k]                    = s_q[k-1];
            s_d[k][k*CHUNK +: CHUNK]  = slice_r[k][CHUNK-1:0];
            c_d[k]                    = slice_r[k][CHUNK];
            v_d[k]                    = v_q[k-1];
        end

        ovf_d  = (a_d[NCH-1][WIDTH-1] == b_d[NCH-1][WIDTH-1]) &
                 (s_d[NCH-1][WIDTH-1] != a_d[NCH-1][WIDTH-1]);
        zero_d = ~|s_d[NCH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q    <= '0;
            v_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            // The output stage ignores bubbles so the last result stays visible.
            for (int k = 0; k < NCH; k++) begin
                v_q[k] <= v_d[k];
                if ((k < NCH - 1) || v_d[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
            if (v_d[NCH-1]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = v_q[NCH-1];
    assign bus.sum       = s_q[NCH-1];
    assign bus.cout      = c_q[NCH-1];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule
